// File: rtl/intorec_sched_pkg.sv
// Shared constants, state encoding and helpers for the
// iNToRecFN sharing scheduler.
package intorec_sched_pkg;

   localparam logic [2:0] RM_NEAR_EVEN   = 3'b000;
   localparam logic [2:0] RM_MINMAG      = 3'b001;
   localparam logic [2:0] RM_MIN         = 3'b010;
   localparam logic [2:0] RM_MAX         = 3'b011;
   localparam logic [2:0] RM_NEAR_MAXMAG = 3'b100;
   localparam logic [2:0] RM_ODD         = 3'b110;

   localparam int FLAGS_W = 5;

   typedef enum logic [1:0] {
      RUN   = 2'd0,
      DRAIN = 2'd1,
      HALT  = 2'd2
   } state_e;

   function automatic int clog2(input int n);
      int r;
      r = 0;
      for (int i = 0; i < 31; i++) begin
         if ((1 << i) < n) r = i + 1;
      end
      return r;
   endfunction

endpackage

// File: rtl/intorec_sched_rr_arb.sv
// Round-robin arbiter: search starts at the index after the last
// grant; the pointer advances only when a grant is issued.
module intorec_rr_arb
   import intorec_sched_pkg::*;
#(
   parameter  int N = 4,
   localparam int W = clog2(N)
) (
   input  logic         clock,
   input  logic         reset,
   input  logic [N-1:0] req,
   input  logic         en,
   output logic [N-1:0] grant,
   output logic [W-1:0] grant_idx
);

   logic [W-1:0] ptr_q;
   logic [W-1:0] ptr_d;
   logic         found;
   int           j;

   always_comb begin
      found     = 1'b0;
      grant     = '0;
      grant_idx = '0;
      j         = 0;
      for (int i = 0; i < N; i++) begin
         j = int'(ptr_q) + i;
         if (j >= N) j = j - N;
         if (!found && en && req[j]) begin
            found     = 1'b1;
            grant[j]  = 1'b1;
            grant_idx = W'(j);
         end
      end
      ptr_d = ptr_q;
      if (found) begin
         ptr_d = (int'(grant_idx) == N - 1) ? '0 : grant_idx + 1'b1;
      end
   end

   always_ff @(posedge clock) begin
      if (reset) ptr_q <= '0;
      else       ptr_q <= ptr_d;
   end

endmodule

// File: rtl/intorec_sched.sv
// Shares one pipelined iNToRecFN converter among NUM_REQ requesters.
// Define INTOREC_SCHED_STATS_EN to add issue/contention counters.
module intorec_sched
   import intorec_sched_pkg::*;
#(
   parameter int NUM_REQ   = 4,
   parameter int INT_WIDTH = 64,
   parameter int EXP_WIDTH = 11,
   parameter int SIG_WIDTH = 53,
   parameter int LATENCY   = 3
) (
   input  logic                           clock,
   input  logic                           reset,
   input  logic [NUM_REQ-1:0]             req_valid,
   output logic [NUM_REQ-1:0]             req_ready,
   input  logic [NUM_REQ-1:0]             req_signed,
   input  logic [NUM_REQ*INT_WIDTH-1:0]   req_in,
   input  logic [NUM_REQ*3-1:0]           req_rm,
   output logic                           cv_valid,
   output logic                           cv_signedIn,
   output logic [INT_WIDTH-1:0]           cv_in,
   output logic [2:0]                     cv_roundingMode,
   input  logic [EXP_WIDTH+SIG_WIDTH:0]   cv_out,
   input  logic [4:0]                     cv_exceptionFlags,
   output logic [NUM_REQ-1:0]             rsp_valid,
   output logic [EXP_WIDTH+SIG_WIDTH:0]   rsp_out,
   output logic [4:0]                     rsp_flags,
   input  logic                           flush_req,
   output logic                           flush_done
`ifdef INTOREC_SCHED_STATS_EN
   ,
   output logic [31:0]                    stat_issued,
   output logic [31:0]                    stat_contend
`endif
);

   localparam int TAG_W = clog2(NUM_REQ);
   localparam int RES_W = EXP_WIDTH + SIG_WIDTH + 1;

   state_e                       state_q, state_d;
   logic                         flush_done_q, flush_done_d;
   logic                         cv_signed_q, cv_signed_d;
   logic [INT_WIDTH-1:0]         cv_in_q, cv_in_d;
   logic [2:0]                   cv_rm_q, cv_rm_d;
   logic [LATENCY:0]             pv_q, pv_d;
   logic [LATENCY:0][TAG_W-1:0]  pt_q, pt_d;
   logic [NUM_REQ-1:0]           rsp_valid_q, rsp_valid_d;
   logic [RES_W-1:0]             rsp_out_q, rsp_out_d;
   logic [FLAGS_W-1:0]           rsp_flags_q, rsp_flags_d;

   logic                         arb_en;
   logic                         xfer;
   logic [NUM_REQ-1:0]           grant;
   logic [TAG_W-1:0]             gidx;

   assign arb_en = (state_q == RUN) && !flush_req && !reset;

   intorec_rr_arb #(.N(NUM_REQ)) u_arb (
      .clock     (clock),
      .reset     (reset),
      .req       (req_valid),
      .en        (arb_en),
      .grant     (grant),
      .grant_idx (gidx)
   );

   assign xfer = |grant;

   always_comb begin
      cv_signed_d = cv_signed_q;
      cv_in_d     = cv_in_q;
      cv_rm_d     = cv_rm_q;
      if (xfer) begin
         cv_signed_d = req_signed[gidx];
         cv_in_d     = req_in[gidx*INT_WIDTH +: INT_WIDTH];
         cv_rm_d     = req_rm[gidx*3 +: 3];
      end

      // Stage 0 mirrors cv_valid; stage LATENCY lines up with cv_out.
      pv_d    = {pv_q[LATENCY-1:0], xfer};
      pt_d    = pt_q;
      pt_d[0] = gidx;
      for (int k = 1; k <= LATENCY; k++) pt_d[k] = pt_q[k-1];

      rsp_valid_d = '0;
      rsp_out_d   = rsp_out_q;
      rsp_flags_d = rsp_flags_q;
      if (pv_q[LATENCY]) begin
         rsp_valid_d[pt_q[LATENCY]] = 1'b1;
         rsp_out_d                  = cv_out;
         rsp_flags_d                = cv_exceptionFlags;
      end

      state_d = state_q;
      case (state_q)
         RUN:     if (flush_req) state_d = DRAIN;
         DRAIN:   if (pv_q == '0) state_d = HALT;
         HALT:    if (!flush_req) state_d = RUN;
         default: state_d = RUN;
      endcase
      flush_done_d = (state_d == HALT);
   end

`ifdef INTOREC_SCHED_STATS_EN
   logic [31:0] stat_issued_q, stat_issued_d;
   logic [31:0] stat_contend_q, stat_contend_d;
   int          nreq;

   always_comb begin
      nreq = 0;
      for (int i = 0; i < NUM_REQ; i++) nreq = nreq + int'(req_valid[i]);
      stat_issued_d  = stat_issued_q + 32'(xfer);
      stat_contend_d = stat_contend_q
                     + 32'((state_q == RUN) && (nreq >= 2));
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         stat_issued_q  <= '0;
         stat_contend_q <= '0;
      end else begin
         stat_issued_q  <= stat_issued_d;
         stat_contend_q <= stat_contend_d;
      end
   end

   assign stat_issued  = stat_issued_q;
   assign stat_contend = stat_contend_q;
`endif

   always_ff @(posedge clock) begin
      if (reset) begin
         state_q      <= RUN;
         flush_done_q <= 1'b0;
         cv_signed_q  <= 1'b0;
         cv_in_q      <= '0;
         cv_rm_q      <= '0;
         pv_q         <= '0;
         pt_q         <= '0;
         rsp_valid_q  <= '0;
         rsp_out_q    <= '0;
         rsp_flags_q  <= '0;
      end else begin
         state_q      <= state_d;
         flush_done_q <= flush_done_d;
         cv_signed_q  <= cv_signed_d;
         cv_in_q      <= cv_in_d;
         cv_rm_q      <= cv_rm_d;
         pv_q         <= pv_d;
         pt_q         <= pt_d;
         rsp_valid_q  <= rsp_valid_d;
         rsp_out_q    <= rsp_out_d;
         rsp_flags_q  <= rsp_flags_d;
      end
   end

   assign req_ready       = grant;
   assign cv_valid        = pv_q[0];
   assign cv_signedIn     = cv_signed_q;
   assign cv_in           = cv_in_q;
   assign cv_roundingMode = cv_rm_q;
   assign rsp_valid       = rsp_valid_q;
   assign rsp_out         = rsp_out_q;
   assign rsp_flags       = rsp_flags_q;
   assign flush_done      = flush_done_q;

endmodule

// File: tb/tb_intorec_sched.sv
// Directed bench for intorec_sched with a stub converter and an
// in-order response scoreboard.
module tb_intorec_sched;
   import intorec_sched_pkg::*;

   localparam int NR  = 4;
   localparam int IW  = 64;
   localparam int EW  = 11;
   localparam int SW  = 53;
   localparam int LAT = 3;
   localparam int RW  = EW + SW + 1;

   logic              clock = 1'b0;
   logic              reset = 1'b1;
   logic [NR-1:0]     req_valid, req_ready, req_signed, rsp_valid;
   logic [NR*IW-1:0]  req_in;
   logic [NR*3-1:0]   req_rm;
   logic              cv_valid, cv_signedIn;
   logic [IW-1:0]     cv_in;
   logic [2:0]        cv_roundingMode;
   logic [RW-1:0]     cv_out, rsp_out;
   logic [4:0]        cv_exceptionFlags, rsp_flags;
   logic              flush_req, flush_done;
`ifdef INTOREC_SCHED_STATS_EN
   logic [31:0]       stat_issued, stat_contend;
`endif

   always #5 clock = ~clock;

   intorec_sched #(
      .NUM_REQ(NR), .INT_WIDTH(IW), .EXP_WIDTH(EW),
      .SIG_WIDTH(SW), .LATENCY(LAT)
   ) dut (
      .clock             (clock),
      .reset             (reset),
      .req_valid         (req_valid),
      .req_ready         (req_ready),
      .req_signed        (req_signed),
      .req_in            (req_in),
      .req_rm            (req_rm),
      .cv_valid          (cv_valid),
      .cv_signedIn       (cv_signedIn),
      .cv_in             (cv_in),
      .cv_roundingMode   (cv_roundingMode),
      .cv_out            (cv_out),
      .cv_exceptionFlags (cv_exceptionFlags),
      .rsp_valid         (rsp_valid),
      .rsp_out           (rsp_out),
      .rsp_flags         (rsp_flags),
      .flush_req         (flush_req),
      .flush_done        (flush_done)
`ifdef INTOREC_SCHED_STATS_EN
      ,
      .stat_issued       (stat_issued),
      .stat_contend      (stat_contend)
`endif
   );

   // Stub converter: a reversible scramble of the operand, LAT cycles deep.
   function automatic logic [RW+4:0] conv(input logic s, input logic [2:0] rm,
                                          input logic [IW-1:0] x);
      return {s, x ^ 64'h0123_4567_89ab_cdef, rm, s, x[0]};
   endfunction

   logic [67:0] cpipe [LAT];
   always @(posedge clock) begin
      cpipe[0] <= cv_valid ? {cv_signedIn, cv_roundingMode, cv_in} : '0;
      for (int k = 1; k < LAT; k++) cpipe[k] <= cpipe[k-1];
   end
   assign {cv_out, cv_exceptionFlags} =
      conv(cpipe[LAT-1][67], cpipe[LAT-1][66:64], cpipe[LAT-1][63:0]);

   typedef struct {
      int            tag;
      logic [RW-1:0] out;
      logic [4:0]    fl;
      int            cyc;
   } exp_t;

   exp_t        sb[$];
   int          grant_log[$];
   int          n_pass  = 0;
   int          n_fail  = 0;
   int          n_total = 0;
   int          n_rsp   = 0;
   int          cyc     = 0;
   logic [NR-1:0] acc_mask = '0;
   logic [2:0]  rm_tab [6];

   task automatic chk(input string tag, input logic [127:0] obs,
                      input logic [127:0] want);
      n_total++;
      assert (obs === want) n_pass++;
      else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, want);
      end
   endtask

   always @(posedge clock) cyc <= cyc + 1;

   exp_t e_mon;
   always @(negedge clock) begin
      acc_mask = req_valid & req_ready;
      if (reset) begin
         sb.delete();
      end else begin
         if (acc_mask != '0) chk("grant_onehot", $countones(acc_mask), 1);
         for (int i = 0; i < NR; i++) begin
            if (acc_mask[i]) begin
               e_mon.tag = i;
               {e_mon.out, e_mon.fl} = conv(req_signed[i], req_rm[i*3 +: 3],
                                            req_in[i*IW +: IW]);
               e_mon.cyc = cyc + 2 + LAT;
               sb.push_back(e_mon);
               grant_log.push_back(i);
            end
         end
         if (rsp_valid != '0) begin
            n_rsp++;
            if (sb.size() == 0) begin
               chk("rsp_unexpected", rsp_valid, 0);
            end else begin
               e_mon = sb.pop_front();
               chk("rsp_valid", rsp_valid, NR'(1) << e_mon.tag);
               chk("rsp_out", rsp_out, e_mon.out);
               chk("rsp_flags", rsp_flags, e_mon.fl);
               chk("rsp_cycle", cyc, e_mon.cyc);
            end
         end else if (sb.size() > 0 && sb[0].cyc < cyc) begin
            chk("rsp_missing", cyc, sb[0].cyc);
            void'(sb.pop_front());
         end
      end
   end

   task automatic new_op(input int i);
      req_in[i*IW +: IW] = {$urandom, $urandom};
      req_signed[i]      = 1'($urandom);
      req_rm[i*3 +: 3]   = rm_tab[$urandom_range(5, 0)];
   endtask

   task automatic step();
      @(posedge clock);
      #1;
      for (int i = 0; i < NR; i++) if (acc_mask[i]) new_op(i);
   endtask

   task automatic wait_drain(input string tag);
      int b;
      b = 0;
      while (sb.size() != 0 && b < 50) begin
         @(negedge clock);
         b++;
      end
      chk(tag, sb.size(), 0);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end

   initial begin
      int r0, last, fd, b;
      rm_tab = '{RM_NEAR_EVEN, RM_MINMAG, RM_MIN, RM_MAX, RM_NEAR_MAXMAG, RM_ODD};
      req_signed = '0;
      req_in     = '0;
      req_rm     = '0;
      flush_req  = 1'b0;
      for (int i = 0; i < NR; i++) new_op(i);
      req_valid = '1;
      reset     = 1'b1;

      // Reset state
      repeat (2) @(posedge clock);
      @(negedge clock);
      chk("rst_req_ready", req_ready, 0);
      chk("rst_cv_valid", cv_valid, 0);
      chk("rst_cv_in", cv_in, 0);
      chk("rst_cv_signed", cv_signedIn, 0);
      chk("rst_cv_rm", cv_roundingMode, 0);
      chk("rst_rsp_valid", rsp_valid, 0);
      chk("rst_rsp_out", rsp_out, 0);
      chk("rst_rsp_flags", rsp_flags, 0);
      chk("rst_flush_done", flush_done, 0);
      @(posedge clock);
      #1;
      reset = 1'b0;

      // All four requesting: strict rotation from 0
      grant_log.delete();
      repeat (12) step();
      req_valid = '0;
      chk("rr_count", grant_log.size(), 12);
      for (int k = 0; k < 12; k++) chk("rr_order", grant_log[k], k % 4);
      wait_drain("rr_drain");

      // Single requester 2 streams 8 operands
      req_valid = 4'b0100;
      for (int k = 0; k < 8; k++) begin
         @(negedge clock);
         chk("single_ready", req_ready, 4'b0100);
         if (k > 0) chk("single_cv_valid", cv_valid, 1);
         step();
      end
      req_valid = '0;
      @(negedge clock);
      chk("single_cv_last", cv_valid, 1);
      step();
      @(negedge clock);
      chk("single_cv_idle", cv_valid, 0);
      wait_drain("single_drain");

      // Pointer at 2 with requesters 1 and 3: grant 3 then 1
      req_valid = 4'b0010;
      step();
      grant_log.delete();
      req_valid = 4'b1010;
      step();
      step();
      req_valid = '0;
      chk("ptr_count", grant_log.size(), 2);
      chk("ptr_first", grant_log[0], 3);
      chk("ptr_second", grant_log[1], 1);
      wait_drain("ptr_drain");

      // Flush with 3 in flight
      r0 = n_rsp;
      req_valid = 4'b0001;
      repeat (3) step();
      flush_req = 1'b1;
      @(negedge clock);
      chk("flush_ready_first", req_ready, 0);
      last = -1;
      fd   = -1;
      b    = 0;
      while (fd < 0 && b < 30) begin
         if (rsp_valid != '0) last = cyc;
         if (flush_done) fd = cyc;
         chk("flush_ready", req_ready, 0);
         @(negedge clock);
         b++;
      end
      chk("flush_rsp_count", n_rsp - r0, 3);
      chk("flush_done_cycle", fd, last + 1);
      @(posedge clock);
      #1;
      flush_req = 1'b0;
      @(negedge clock);
      chk("halt_ready", req_ready, 0);
      chk("halt_flush_done", flush_done, 1);
      step();
      @(negedge clock);
      chk("resume_ready", req_ready, 4'b0001);
      chk("resume_flush_done", flush_done, 0);
      step();
      req_valid = '0;
      wait_drain("flush_drain");

      // Reset with 2 in flight
      req_valid = 4'b0001;
      step();
      step();
      req_valid = '0;
      reset = 1'b1;
      step();
      @(negedge clock);
      chk("mid_rst_cv_valid", cv_valid, 0);
      chk("mid_rst_rsp_valid", rsp_valid, 0);
      chk("mid_rst_cv_in", cv_in, 0);
      chk("mid_rst_rsp_out", rsp_out, 0);
      chk("mid_rst_rsp_flags", rsp_flags, 0);
      chk("mid_rst_flush_done", flush_done, 0);
      r0 = n_rsp;
      @(posedge clock);
      #1;
      reset = 1'b0;
      grant_log.delete();
      req_valid = '1;
      step();
      req_valid = '0;
      chk("post_rst_grant", grant_log[0], 0);
      repeat (10) @(negedge clock);
      chk("post_rst_rsp_count", n_rsp - r0, 1);
      wait_drain("rst_drain");

`ifdef INTOREC_SCHED_STATS_EN
      reset = 1'b1;
      step();
      reset = 1'b0;
      req_valid = 4'b0011;
      repeat (10) step();
      req_valid = '0;
      @(negedge clock);
      chk("stat_issued", stat_issued, 10);
      chk("stat_contend", stat_contend, 10);
      wait_drain("stat_drain");
`endif

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
